// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin ICache/DCache arbiter in front of the single memory_controller port
// MEM_ARB_DPRIO_EN: when defined, DCache (port1) wins every simultaneous request.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        p0_rw_flag,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_write_data,
    input  logic [MASK_W-1:0] p0_write_mask,
    output logic [DATA_W-1:0] p0_read_data,
    output logic              p0_busy,
    output logic              p0_done,
    input  logic [1:0]        p1_rw_flag,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_write_data,
    input  logic [MASK_W-1:0] p1_write_mask,
    output logic [DATA_W-1:0] p1_read_data,
    output logic              p1_busy,
    output logic              p1_done,
    output logic [1:0]        mem_rw_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [MASK_W-1:0] mem_write_mask,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_busy,
    input  logic              mem_done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state, state_nxt;
    logic              grant, grant_nxt;
    logic              last_grant, last_grant_nxt;
    logic [1:0]        mem_rw_flag_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_write_data_nxt;
    logic [MASK_W-1:0] mem_write_mask_nxt;
    logic [DATA_W-1:0] p0_read_data_nxt, p1_read_data_nxt;
    logic              p0_done_nxt, p1_done_nxt;
    logic              req0, req1, tie_pick, pick;

    // Code 11 is deliberately not a request.
    assign req0 = (p0_rw_flag == 2'b01) || (p0_rw_flag == 2'b10);
    assign req1 = (p1_rw_flag == 2'b01) || (p1_rw_flag == 2'b10);

`ifdef MEM_ARB_DPRIO_EN
    assign tie_pick = 1'b1;
`else
    assign tie_pick = ~last_grant;
`endif

    assign pick = (req0 && req1) ? tie_pick : req1;

    always_comb begin
        state_nxt          = state;
        grant_nxt          = grant;
        last_grant_nxt     = last_grant;
        mem_rw_flag_nxt    = mem_rw_flag;
        mem_addr_nxt       = mem_addr;
        mem_write_data_nxt = mem_write_data;
        mem_write_mask_nxt = mem_write_mask;
        p0_read_data_nxt   = p0_read_data;
        p1_read_data_nxt   = p1_read_data;
        p0_done_nxt        = p0_done;
        p1_done_nxt        = p1_done;
        case (state)
            IDLE: begin
                if ((req0 || req1) && !mem_busy) begin
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    state_nxt      = WAIT;
                    if (pick) begin
                        mem_rw_flag_nxt    = p1_rw_flag;
                        mem_addr_nxt       = p1_addr;
                        mem_write_data_nxt = p1_write_data;
                        mem_write_mask_nxt = p1_write_mask;
                    end else begin
                        mem_rw_flag_nxt    = p0_rw_flag;
                        mem_addr_nxt       = p0_addr;
                        mem_write_data_nxt = p0_write_data;
                        mem_write_mask_nxt = p0_write_mask;
                    end
                end
            end
            WAIT: begin
                if (mem_done) begin
                    mem_rw_flag_nxt = 2'b00;
                    state_nxt       = RESP;
                    if (mem_rw_flag == 2'b01) begin
                        if (grant) p1_read_data_nxt = mem_read_data;
                        else       p0_read_data_nxt = mem_read_data;
                    end
                    if (grant) p1_done_nxt = 1'b1;
                    else       p0_done_nxt = 1'b1;
                end
            end
            RESP: begin
                // One dead cycle lets the finishing requester drop its flag before re-arbitration.
                p0_done_nxt = 1'b0;
                p1_done_nxt = 1'b0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= 1'b0;
            last_grant     <= 1'b1;
            mem_rw_flag    <= 2'b00;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write_mask <= '0;
            p0_read_data   <= '0;
            p1_read_data   <= '0;
            p0_done        <= 1'b0;
            p1_done        <= 1'b0;
        end else begin
            state          <= state_nxt;
            grant          <= grant_nxt;
            last_grant     <= last_grant_nxt;
            mem_rw_flag    <= mem_rw_flag_nxt;
            mem_addr       <= mem_addr_nxt;
            mem_write_data <= mem_write_data_nxt;
            mem_write_mask <= mem_write_mask_nxt;
            p0_read_data   <= p0_read_data_nxt;
            p1_read_data   <= p1_read_data_nxt;
            p0_done        <= p0_done_nxt;
            p1_done        <= p1_done_nxt;
        end
    end

    assign p0_busy = (state != IDLE);
    assign p1_busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;

`ifdef MEM_ARB_DPRIO_EN
    localparam bit FIRST_TIE = 1'b1;
    localparam bit SECOND_TIE = 1'b1;
`else
    localparam bit FIRST_TIE = 1'b0;
    localparam bit SECOND_TIE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_flag [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wd   [2];
    logic [3:0]  req_mask [2];
    logic [31:0] p0_read_data, p1_read_data;
    logic        p0_busy, p1_busy, p0_done, p1_done;
    logic [1:0]  mem_rw_flag;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_write_mask;
    logic [31:0] mem_read_data;
    logic        mem_busy, mem_done;

    int errors = 0;
    int checks = 0;

    // Model: one outstanding transaction, then one response cycle, then back to arbitration.
    bit          m_active, m_cool, m_owner, m_last;
    logic [1:0]  m_flag;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_mask;
    logic [31:0] m_rd [2];
    bit          m_done [2];

    bit pending [2];
    bit ctrl_on;
    int ctrl_cnt;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_rw_flag(req_flag[0]), .p0_addr(req_addr[0]), .p0_write_data(req_wd[0]),
        .p0_write_mask(req_mask[0]), .p0_read_data(p0_read_data), .p0_busy(p0_busy), .p0_done(p0_done),
        .p1_rw_flag(req_flag[1]), .p1_addr(req_addr[1]), .p1_write_data(req_wd[1]),
        .p1_write_mask(req_mask[1]), .p1_read_data(p1_read_data), .p1_busy(p1_busy), .p1_done(p1_done),
        .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write_mask(mem_write_mask), .mem_read_data(mem_read_data), .mem_busy(mem_busy),
        .mem_done(mem_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_cool = 0; m_owner = 0; m_last = 1;
        m_flag = 0; m_addr = 0; m_wd = 0; m_mask = 0;
        m_rd[0] = 0; m_rd[1] = 0; m_done[0] = 0; m_done[1] = 0;
    endtask

    function automatic bit valid_req(input logic [1:0] f);
        return (f == 2'd1) || (f == 2'd2);
    endfunction

    task automatic model_update();
        bit r0, r1, w;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_cool) begin
            m_done[0] = 0; m_done[1] = 0; m_cool = 0;
        end else if (m_active) begin
            if (mem_done) begin
                if (m_flag == 2'd1) m_rd[m_owner] = mem_read_data;
                m_done[m_owner] = 1;
                m_flag = 0; m_active = 0; m_cool = 1;
            end
        end else begin
            r0 = valid_req(req_flag[0]);
            r1 = valid_req(req_flag[1]);
            if ((r0 || r1) && !mem_busy) begin
`ifdef MEM_ARB_DPRIO_EN
                w = (r0 && r1) ? 1'b1 : r1;
`else
                w = (r0 && r1) ? !m_last : r1;
`endif
                m_owner = w; m_last = w; m_active = 1;
                m_flag = req_flag[w]; m_addr = req_addr[w];
                m_wd = req_wd[w]; m_mask = req_mask[w];
            end
        end
    endtask

    task automatic compare_all();
        check("mem_rw_flag", {30'd0, mem_rw_flag}, {30'd0, m_flag});
        check("mem_addr", mem_addr, m_addr);
        check("mem_write_data", mem_write_data, m_wd);
        check("mem_write_mask", {28'd0, mem_write_mask}, {28'd0, m_mask});
        check("p0_read_data", p0_read_data, m_rd[0]);
        check("p1_read_data", p1_read_data, m_rd[1]);
        check("p0_done", {31'd0, p0_done}, {31'd0, m_done[0]});
        check("p1_done", {31'd0, p1_done}, {31'd0, m_done[1]});
        check("p0_busy", {31'd0, p0_busy}, {31'd0, m_active | m_cool});
        check("p1_busy", {31'd0, p1_busy}, {31'd0, m_active | m_cool});
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_req(input int p, input logic [1:0] f, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        req_flag[p] = f; req_addr[p] = a; req_wd[p] = d; req_mask[p] = m;
    endtask

    task automatic serve(input logic [31:0] rdata);
        mem_done = 1; mem_read_data = rdata;
        tick();
        mem_done = 0; mem_read_data = 0;
    endtask

    task automatic finish_req();
        for (int p = 0; p < 2; p++) if (m_done[p]) req_flag[p] = 0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        compare_all();
        tick();
        rst = 0;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) set_req(p, 0, 0, 0, 0);
        mem_read_data = 0; mem_busy = 0; mem_done = 0;
        rst = 1;
        model_reset();
        @(negedge clk);
        compare_all();
        check("reset_mem_rw_flag", {30'd0, mem_rw_flag}, 32'd0);
        check("reset_p0_busy", {31'd0, p0_busy}, 32'd0);
        tick();
        rst = 0;

        // Single read
        set_req(0, 2'b01, 32'h100, 0, 0);
        tick();
        check("t1_issue_flag", {30'd0, mem_rw_flag}, 32'd1);
        check("t1_addr", mem_addr, 32'h100);
        tick(); tick();
        serve(32'hDEADBEEF);
        check("t1_done", {31'd0, p0_done}, 32'd1);
        check("t1_rdata", p0_read_data, 32'hDEADBEEF);
        check("t1_flag_cleared", {30'd0, mem_rw_flag}, 32'd0);
        finish_req();
        check("t1_done_one_cycle", {31'd0, p0_done}, 32'd0);

        // Simultaneous requests after reset
        do_reset();
        set_req(0, 2'b01, 32'h10, 0, 0);
        set_req(1, 2'b10, 32'h20, 32'h55AA, 4'hF);
        tick();
        check("t2_first_addr", mem_addr, FIRST_TIE ? 32'h20 : 32'h10);
        serve(32'h1234);
        finish_req();
        tick();
        check("t2_second_addr", mem_addr, FIRST_TIE ? 32'h10 : 32'h20);
        serve(32'h5678);
        check("t2_p1_done", {31'd0, p1_done}, FIRST_TIE ? 32'd0 : 32'd1);
        check("t2_p1_rdata_unchanged", p1_read_data, 32'd0);
        check("t2_p0_rdata", p0_read_data, FIRST_TIE ? 32'h5678 : 32'h1234);
        finish_req();
        if (!FIRST_TIE) begin
            check("t2_wdata", mem_write_data, 32'h55AA);
            check("t2_wmask", {28'd0, mem_write_mask}, 32'hF);
        end
        set_req(0, 2'b01, 32'h10, 0, 0);
        set_req(1, 2'b10, 32'h20, 32'h55AA, 4'hF);
        tick();
        check("t2_second_tie_addr", mem_addr, SECOND_TIE ? 32'h20 : 32'h10);
        serve(32'h9);
        finish_req();
        tick();
        serve(32'hA);
        finish_req();

        // Backpressure
        mem_busy = 1;
        set_req(1, 2'b01, 32'h40, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_held_off", {30'd0, mem_rw_flag}, 32'd0);
        end
        mem_busy = 0;
        tick();
        check("t3_issue", {30'd0, mem_rw_flag}, 32'd1);
        check("t3_addr", mem_addr, 32'h40);

        // Reset mid-transaction
        tick();
        rst = 1;
        #1;
        model_reset();
        check("t4_flag_zero", {30'd0, mem_rw_flag}, 32'd0);
        check("t4_addr_zero", mem_addr, 32'd0);
        check("t4_busy_zero", {31'd0, p1_busy}, 32'd0);
        compare_all();
        set_req(1, 0, 0, 0, 0);
        tick();
        rst = 0;
        set_req(0, 2'b01, 32'h200, 0, 0);
        tick();
        check("t4_new_issue", {30'd0, mem_rw_flag}, 32'd1);
        check("t4_new_addr", mem_addr, 32'h200);
        serve(32'hCAFEF00D);
        check("t4_rdata", p0_read_data, 32'hCAFEF00D);
        finish_req();

        // Ignored code 11
        set_req(0, 2'b11, 32'h300, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_no_issue", {30'd0, mem_rw_flag}, 32'd0);
            check("t5_not_busy", {31'd0, p0_busy}, 32'd0);
        end
        set_req(0, 0, 0, 0, 0);
        tick();

        // Randomized traffic
        pending[0] = 0; pending[1] = 0; ctrl_on = 0; ctrl_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (pending[p]) begin
                    if (m_done[p]) begin
                        req_flag[p] = 0; pending[p] = 0;
                    end else if (m_active && m_owner == p && $urandom_range(0, 7) == 0) begin
                        req_addr[p] = $urandom; req_wd[p] = $urandom;
                    end
                end else begin
                    case ($urandom_range(0, 9))
                        0, 1, 2: begin
                            set_req(p, 2'($urandom_range(1, 2)), $urandom, $urandom,
                                    4'($urandom_range(0, 15)));
                            pending[p] = 1;
                        end
                        3:       req_flag[p] = 2'b11;
                        default: req_flag[p] = 2'b00;
                    endcase
                end
            end
            if (m_active && !ctrl_on) begin
                ctrl_on = 1; ctrl_cnt = $urandom_range(0, 3);
            end
            if (ctrl_on) begin
                if (ctrl_cnt == 0) begin
                    mem_done = 1; mem_read_data = $urandom; ctrl_on = 0;
                end else begin
                    ctrl_cnt--; mem_done = 0;
                end
                mem_busy = 1;
            end else begin
                mem_done = ($urandom_range(0, 19) == 0);
                mem_read_data = $urandom;
                mem_busy = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single memory_controller port between ICache (port 0) and DCache (port 1).
- Sits between the caches and the cpu_core memory interface.
- Each side uses the same rw_flag/addr/read_data/write_data/write_mask/busy/done handshake.
- Serialises transactions with round-robin fairness; exactly one outstanding memory transaction at a time.

Parameters:
ADDR_W, 32, address width (matches `addrWidth)
DATA_W, 32, data width (matches `dataWidth)
MASK_W, 4, byte write mask width (matches `maskWidth)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
p0_rw_flag  in  2  port0 request: 00 idle, 01 read, 10 write, 11 ignored
p0_addr  in  ADDR_W  port0 address
p0_write_data  in  DATA_W  port0 write data
p0_write_mask  in  MASK_W  port0 byte mask
p0_read_data  out  DATA_W  port0 read result (registered)
p0_busy  out  1  arbiter occupied
p0_done  out  1  one-cycle completion pulse for port0
p1_* (rw_flag, addr, write_data, write_mask, read_data, busy, done)  same as p0_*, for port1
mem_rw_flag  out  2  request to memory_controller (registered)
mem_addr  out  ADDR_W  registered address
mem_write_data  out  DATA_W  registered write data
mem_write_mask  out  MASK_W  registered mask
mem_read_data  in  DATA_W  controller read data, valid with mem_done
mem_busy  in  1  controller cannot accept a new request
mem_done  in  1  controller completion pulse

Behaviour:
- Reset (async, rst=1): state=IDLE, last_grant=1, all outputs 0 (mem_rw_flag=00, pN_done=0, pN_read_data=0, mem_addr/data/mask=0). A transaction in flight is abandoned; the controller shares the same rst.
- Requester contract: hold rw_flag/addr/data/mask stable from assertion until it samples pN_done=1; drop rw_flag at that edge.
- Valid request: rw_flag is 01 or 10. A value of 11 is treated as no request.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any valid request and mem_busy=0: choose grant, latch the port's flag/addr/data/mask into the mem_* registers, grant<=chosen, last_grant<=chosen, go to WAIT.
  - If mem_busy=1: stay in IDLE, issue nothing.
- Grant rule:
  - Only one port requesting: that port wins.
  - Both requesting: the port != last_grant wins. After reset, port0 wins the first tie.
- WAIT:
  - mem_* outputs held constant.
  - On mem_done=1: mem_rw_flag<=00; if the latched op was a read, p[grant]_read_data<=mem_read_data (otherwise unchanged); p[grant]_done<=1; go to RESP.
- RESP: pN_done<=0, go to IDLE. No grant is issued in RESP, so the finishing requester's stale flag is never re-served.
- pN_busy = (state != IDLE), identical on both ports. The non-granted port's read_data is never modified.
- Latency:
  - Request first visible in cycle c (IDLE, mem_busy=0) -> mem_rw_flag valid in cycle c+1.
  - mem_done in cycle d -> pN_done high in cycle d+1.
  - Next grant is sampled in cycle d+2; its mem_rw_flag is high in cycle d+3.
- A request arriving during WAIT/RESP is queued implicitly: the requester keeps holding and is arbitered on return to IDLE.
- A request change mid-transaction (contract violation) has no effect; the latched copy is used.
- mem_done while in IDLE or RESP is ignored.
- No combinational path from any input to any output.

Optional Feature:
MEM_ARB_DPRIO_EN:
- Defined: when both ports request in IDLE, port1 (DCache) always wins; last_grant is not used for the decision but is still updated. This gives fixed priority to data accesses.
- Undefined: round-robin as described.

Test Plan:
- Single read: p0_rw_flag=01, p0_addr=0x100; controller returns mem_done with mem_read_data=0xDEADBEEF 3 cycles after mem_rw_flag=01 -> mem_addr=0x100 one cycle after the request; p0_read_data=0xDEADBEEF and p0_done=1 for exactly one cycle; mem_rw_flag=00 after done.
- Simultaneous requests after reset: p0 read 0x10, p1 write 0x20 with data 0x55AA, mask 0xF -> port0 served first, then port1 (mem_write_data=0x55AA, mask=0xF). The next tie goes to port0 again (alternation). With MEM_ARB_DPRIO_EN, port1 is served first on every tie.
- Backpressure: mem_busy=1 for 5 cycles while p1 requests -> mem_rw_flag stays 00; issue occurs the cycle after mem_busy falls.
- Write isolation: p1 write completes -> p1_read_data unchanged, p0_read_data unchanged, p1_done pulse only.
- Reset mid-WAIT: assert rst while mem_rw_flag=01 -> all outputs 0 immediately; after release, a new p0 read proceeds normally.
- Ignored codes: p0_rw_flag=11 for 10 cycles -> no mem request issued, p0_busy stays 0.
